// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//
// Writeback stage of the 16-bit pipelined core. It takes the MEM/WB
// pipeline-register outputs, picks the word to write back, and drives the
// single register-file write port.
//
// Two-word results (multiply high word, divide remainder) need two writes
// through the one port. The low word is written to Rd in the first cycle
// while the pipeline is stalled. The high word is written to HI_REG in the
// following cycle, which is the SECOND state.
//
// The block also keeps a registered copy of the last committed write
// (Last_*) for the forwarding unit.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   MemToReg_in    1 = write ReadData_in, 0 = write ALU_Result_in
//   RegWrite_in    WB instruction writes the register file (WB valid)
//   ALU_Result_in  ALU result / low word of two-word results
//   ReadData_in    data-memory read word
//   HiWord_in      multiply high word or divide remainder
//   movOP_in       4'h1 MUL two-word, 4'h2 DIV two-word, else normal
//   Rd_in          destination register
//   RegWriteEn     register-file write enable
//   WriteReg       register-file write index
//   WriteData      register-file write data
//   WB_Stall       hold IF..MEM and the MEM/WB buffer this cycle
//   Last_Valid     Last_Reg/Last_Data describe a committed write
//   Last_Reg       index of the write committed at the previous edge
//   Last_Data      data of the write committed at the previous edge
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int                DATA_W = 16,
  parameter int                REG_AW = 4,
  parameter logic [REG_AW-1:0] HI_REG = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  input  logic [DATA_W-1:0] ALU_Result_in,
  input  logic [DATA_W-1:0] ReadData_in,
  input  logic [DATA_W-1:0] HiWord_in,
  input  logic [3:0]        movOP_in,
  input  logic [REG_AW-1:0] Rd_in,
  output logic              RegWriteEn,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              WB_Stall,
  output logic              Last_Valid,
  output logic [REG_AW-1:0] Last_Reg,
  output logic [DATA_W-1:0] Last_Data
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } wb_state_t;

  localparam logic [3:0] OP_MUL = 4'h1;
  localparam logic [3:0] OP_DIV = 4'h2;

  wb_state_t         state;
  logic [DATA_W-1:0] hi_hold;
  logic [DATA_W-1:0] wb_word;
  logic              two_word;

  // A two-word op only counts when the WB slot actually holds a writing
  // instruction; a stale movOP on a bubble must not start the sequence.
  always_comb begin
    wb_word  = MemToReg_in ? ReadData_in : ALU_Result_in;
    two_word = RegWrite_in && ((movOP_in == OP_MUL) || (movOP_in == OP_DIV));
  end

  // Write-port outputs are combinational so a normal write commits at the
  // same edge it is presented. Reset forces the port quiet immediately,
  // even between clock edges. In SECOND all inputs are ignored.
  always_comb begin
    RegWriteEn = 1'b0;
    WriteReg   = '0;
    WriteData  = '0;
    WB_Stall   = 1'b0;
    if (rst_n) begin
      if (state == SECOND) begin
        RegWriteEn = 1'b1;
        WriteReg   = HI_REG;
        WriteData  = hi_hold;
      end else begin
        RegWriteEn = RegWrite_in;
        WriteReg   = Rd_in;
        // The low word of a two-word result always comes from the ALU path.
        WriteData  = two_word ? ALU_Result_in : wb_word;
        WB_Stall   = two_word;
      end
    end
  end

  // Sequencer plus the last-write register for forwarding. Asserting reset
  // in SECOND simply drops the pending high word; nothing replays it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hi_hold    <= '0;
      Last_Valid <= 1'b0;
      Last_Reg   <= '0;
      Last_Data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (two_word) begin
            hi_hold <= HiWord_in;
            state   <= SECOND;
          end
        end
        SECOND: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (RegWriteEn) begin
        Last_Valid <= 1'b1;
        Last_Reg   <= WriteReg;
        Last_Data  <= WriteData;
      end else begin
        Last_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
//
// Scoreboard bench for wb_stage. The driver applies one input set per
// cycle on the falling edge and pushes the expected port state for that
// cycle. A separate monitor samples the DUT shortly after and pops the
// expectations to compare.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              MemToReg_in = 1'b0;
  logic              RegWrite_in = 1'b0;
  logic [DATA_W-1:0] ALU_Result_in = '0;
  logic [DATA_W-1:0] ReadData_in = '0;
  logic [DATA_W-1:0] HiWord_in = '0;
  logic [3:0]        movOP_in = '0;
  logic [REG_AW-1:0] Rd_in = '0;
  logic              RegWriteEn;
  logic [REG_AW-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              WB_Stall;
  logic              Last_Valid;
  logic [REG_AW-1:0] Last_Reg;
  logic [DATA_W-1:0] Last_Data;

  wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .HI_REG(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
    .ALU_Result_in(ALU_Result_in), .ReadData_in(ReadData_in),
    .HiWord_in(HiWord_in), .movOP_in(movOP_in), .Rd_in(Rd_in),
    .RegWriteEn(RegWriteEn), .WriteReg(WriteReg), .WriteData(WriteData),
    .WB_Stall(WB_Stall), .Last_Valid(Last_Valid), .Last_Reg(Last_Reg),
    .Last_Data(Last_Data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        stall;
    logic [3:0]  wreg;
    logic [15:0] wdata;
    logic        lv;
    logic [3:0]  lreg;
    logic [15:0] ldata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a pending high word waiting for its turn, plus the
  // last write the register file saw.
  bit          m_pend = 0;
  logic [15:0] m_hi = '0;
  bit          m_lv = 0;
  logic [3:0]  m_lreg = '0;
  logic [15:0] m_ldata = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    m_pend  = 0;
    m_hi    = '0;
    m_lv    = 0;
    m_lreg  = '0;
    m_ldata = '0;
  endtask

  task automatic applyStimulus(input logic rst_v, input logic rw, input logic m2r,
                               input logic [3:0] op, input logic [3:0] rd,
                               input logic [15:0] alu, input logic [15:0] rdata,
                               input logic [15:0] hi);
    exp_t e;
    bit   is_two;
    @(negedge clk);
    rst_n = rst_v; RegWrite_in = rw; MemToReg_in = m2r; movOP_in = op;
    Rd_in = rd; ALU_Result_in = alu; ReadData_in = rdata; HiWord_in = hi;
    is_two = rw && (op == 4'h1 || op == 4'h2);
    e = '0;
    if (!rst_v) modelReset();
    e.lv = m_lv; e.lreg = m_lreg; e.ldata = m_ldata;
    if (!rst_v) begin
      e.en = 0; e.stall = 0; e.wreg = 0; e.wdata = 0;
    end else if (m_pend) begin
      e.en = 1; e.stall = 0; e.wreg = 4'd0; e.wdata = m_hi;
    end else begin
      e.en    = rw;
      e.stall = is_two;
      e.wreg  = rd;
      e.wdata = is_two ? alu : (m2r ? rdata : alu);
    end
    sb.push_back(e);
    // Effect of the coming rising edge.
    if (rst_v) begin
      if (e.en) begin
        m_lv = 1; m_lreg = e.wreg; m_ldata = e.wdata;
      end else begin
        m_lv = 0;
      end
      if (m_pend) m_pend = 0;
      else if (is_two) begin
        m_pend = 1; m_hi = hi;
      end
    end
  endtask

  task automatic applyGarbage();
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
                  4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // Monitor: samples between the falling-edge drive and the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("RegWriteEn", 32'(RegWriteEn), 32'(e.en));
        checkOutput("WB_Stall",   32'(WB_Stall),   32'(e.stall));
        checkOutput("WriteReg",   32'(WriteReg),   32'(e.wreg));
        checkOutput("WriteData",  32'(WriteData),  32'(e.wdata));
        checkOutput("Last_Valid", 32'(Last_Valid), 32'(e.lv));
        checkOutput("Last_Reg",   32'(Last_Reg),   32'(e.lreg));
        checkOutput("Last_Data",  32'(Last_Data),  32'(e.ldata));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset held, then the directed cases.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h1, 4'd9, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 16'h0, 16'h0, 16'h0);
    // ALU op, then load.
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 4'd3, 16'h1234, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h0, 4'd5, 16'h0040, 16'hBEEF, 16'h0000);
    // MUL two-word, garbage in SECOND, then a normal op.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h1, 4'd2, 16'h5678, 16'hDEAD, 16'h0009);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h2, 4'd15, 16'hF00D, 16'hCAFE, 16'h7777);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 4'd4, 16'h0101, 16'h0000, 16'h0000);
    // Back-to-back DIV ops.
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h2, 4'd7, 16'h0003, 16'h0000, 16'h0001);
    applyGarbage();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h2, 4'd0, 16'h0010, 16'h0000, 16'h0002);
    applyGarbage();
    // Bubble carrying a stale MUL op.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, 4'd6, 16'h1111, 16'h2222, 16'h3333);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'd1, 16'h0000, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 4'd8, 16'h0808, 16'h0000, 16'h0000);
    // Async reset in the middle of SECOND.
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h1, 4'd9, 16'h4321, 16'h0000, 16'h00AB);
    applyGarbage();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_RegWriteEn", 32'(RegWriteEn), 32'h0);
    checkOutput("async_WB_Stall",   32'(WB_Stall),   32'h0);
    checkOutput("async_WriteReg",   32'(WriteReg),   32'h0);
    checkOutput("async_WriteData",  32'(WriteData),  32'h0);
    modelReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'd1, 16'h1, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'd1, 16'h1, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'd2, 16'h2, 16'h0, 16'h0);

    // Randomized traffic with occasional resets.
    repeat (400) begin
      applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                    1'($urandom), 4'($urandom_range(0, 5)), 4'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom));
    end

    @(negedge clk);
    #5;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
